// File: rtl/bar_update_scheduler.sv
// ---------------------------------------------------------------------------
// bar_update_scheduler
//
// Once per video frame, when a fresh spectrum is waiting, walks the spectrum
// memory bar by bar, averages the bins that belong to each bar, blends the
// average into the previously displayed height (7/8 old + 1/8 new) and writes
// the result into the bar register file.
//
// Ports
//   clk_25MHz      in   pixel clock; everything runs on its rising edge
//   rst            in   asynchronous, active-low reset
//   fft_done       in   one-cycle pulse: a new spectrum is ready
//   vsync          in   VGA vertical sync (already in the clk_25MHz domain)
//   bin_rd         out  read strobe to the spectrum memory
//   bin_addr       out  bin index, valid with bin_rd
//   bin_data       in   bin magnitude, valid one cycle after bin_rd
//   bar_we         out  one-cycle write strobe to the bar register file
//   bar_idx        out  bar being written, valid with bar_we
//   bar_val        out  smoothed bar height, valid with bar_we
//   busy           out  high while an update sequence runs
//   frame_skipped  out  one-cycle pulse: frame start arrived while busy
// ---------------------------------------------------------------------------
module bar_update_scheduler #(
    parameter int WIDTH = 12,
    parameter int N     = 256,
    parameter int BARS  = 16,
    parameter int BAR_W = 6
) (
    input  logic                    clk_25MHz,
    input  logic                    rst,
    input  logic                    fft_done,
    input  logic                    vsync,
    output logic                    bin_rd,
    output logic [$clog2(N)-1:0]    bin_addr,
    input  logic [WIDTH:0]          bin_data,
    output logic                    bar_we,
    output logic [$clog2(BARS)-1:0] bar_idx,
    output logic [BAR_W-1:0]        bar_val,
    output logic                    busy,
    output logic                    frame_skipped
);

    localparam int AW = $clog2(N);
    localparam int IW = $clog2(BARS);

    // Logarithmic bar-to-bin map: first bin of each bar and log2 of its bin count.
    localparam logic [AW-1:0] FIRST_BIN [0:BARS-1] = '{
        8'd2,  8'd3,  8'd4,  8'd5,  8'd6,  8'd7,  8'd8,  8'd9,
        8'd11, 8'd13, 8'd17, 8'd21, 8'd29, 8'd37, 8'd53, 8'd69
    };
    localparam logic [2:0] LOG2_CNT [0:BARS-1] = '{
        3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1,
        3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4, 3'd5
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        LAST   = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [1:0]       vs_hist;        // [1] = older sample, [0] = newer sample
    logic             frame_start;
    logic             pending;
    logic             start;

    logic [IW-1:0]    bar;            // bar currently being processed
    logic [4:0]       cnt;            // reads issued so far for this bar
    logic [4:0]       cnt_last;
    logic             last_issue;
    logic [AW-1:0]    addr;

    logic [4:0]       sample;         // top five magnitude bits of one bin
    logic [9:0]       acc;
    logic [9:0]       avg;
    logic [8:0]       old7;
    logic [9:0]       smooth_sum;
    logic [BAR_W-1:0] new_val;

    logic [BAR_W-1:0] held [BARS];    // last displayed height per bar
    logic [IW-1:0]    idx_q;          // bar_idx / bar_val hold between strobes
    logic [BAR_W-1:0] val_q;

    logic             unused_low;

    // Only the top five magnitude bits contribute to a bar.
    assign sample     = bin_data[WIDTH -: 5];
    assign unused_low = ^bin_data[WIDTH-5:0];

    assign frame_start = (vs_hist == 2'b01);
    assign start       = frame_start && pending && (state == IDLE);

    assign cnt_last   = 5'((6'd1 << LOG2_CNT[bar]) - 6'd1);
    assign last_issue = (cnt == cnt_last);

    // Average over a power-of-two bin count, then blend 1/8 new + 7/8 old.
    // The sum cannot exceed 58 with these widths; the clamp keeps it safe if
    // the accumulator or bar width is ever changed.
    assign avg        = acc >> LOG2_CNT[bar];
    assign old7       = 9'(held[bar]) * 9'd7;
    assign smooth_sum = 10'(avg[9:3]) + 10'(old7[8:3]);
    assign new_val    = (|smooth_sum[9:BAR_W]) ? '1 : smooth_sum[BAR_W-1:0];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk_25MHz or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    // NOTE: default assignment first, so no path through the case leaves
    // state_nxt unassigned and infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ISSUE;
            ISSUE:   if (last_issue) state_nxt = LAST;
            LAST:    state_nxt = COMMIT;
            COMMIT:  state_nxt = (bar == IW'(BARS - 1)) ? IDLE : ISSUE;
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        bin_rd = 1'b0;
        bar_we = 1'b0;
        busy   = 1'b0;
        case (state)
            ISSUE:  begin bin_rd = 1'b1; busy = 1'b1; end
            LAST:   busy = 1'b1;
            COMMIT: begin bar_we = 1'b1; busy = 1'b1; end
            default: ;
        endcase
    end

    assign frame_skipped = frame_start && busy;
    assign bin_addr      = addr;
    assign bar_idx       = bar_we ? bar : idx_q;
    assign bar_val       = bar_we ? new_val : val_q;

    // ------------------------------------------------------------------
    // Datapath: trigger detection, address walk, accumulate, smooth
    // ------------------------------------------------------------------
    // NOTE: the per-bar history is cleared by reset so a restarted display
    // never blends in heights from before the reset.
    always_ff @(posedge clk_25MHz or negedge rst) begin
        if (!rst) begin
            vs_hist <= '0;
            pending <= 1'b0;
            bar     <= '0;
            cnt     <= '0;
            addr    <= '0;
            acc     <= '0;
            idx_q   <= '0;
            val_q   <= '0;
            for (int i = 0; i < BARS; i++) begin
                held[i] <= '0;
            end
        end else begin
            vs_hist <= {vs_hist[0], vsync};

            // A new spectrum arriving in the start cycle stays pending.
            if (fft_done) begin
                pending <= 1'b1;
            end else if (start) begin
                pending <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        bar  <= '0;
                        cnt  <= '0;
                        addr <= FIRST_BIN[0];
                    end
                end
                ISSUE: begin
                    // Data for the read issued last cycle arrives now; the
                    // first cycle of a bar has nothing in flight.
                    if (cnt == 5'd0) begin
                        acc <= '0;
                    end else begin
                        acc <= acc + 10'(sample);
                    end
                    if (!last_issue) begin
                        cnt  <= cnt + 5'd1;
                        addr <= addr + AW'(1);
                    end
                end
                LAST: begin
                    acc <= acc + 10'(sample);
                end
                COMMIT: begin
                    held[bar] <= new_val;
                    idx_q     <= bar;
                    val_q     <= new_val;
                    if (bar != IW'(BARS - 1)) begin
                        bar  <= bar + IW'(1);
                        cnt  <= '0;
                        addr <= FIRST_BIN[bar + IW'(1)];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bar_update_scheduler.sv
// ---------------------------------------------------------------------------
// tb_bar_update_scheduler
//
// Drives bar_update_scheduler with directed scenarios and randomized
// fft_done / vsync / reset traffic. A behavioural model turns each sequence
// start into the full list of expected per-cycle outputs (computed from the
// bar-to-bin map with plain division), and one compare process checks every
// output on every falling edge. Directed scenarios add literal expectations.
// ---------------------------------------------------------------------------
module tb_bar_update_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        fft_done;
    logic        vsync;
    logic        bin_rd;
    logic [7:0]  bin_addr;
    logic [12:0] bin_data;
    logic        bar_we;
    logic [3:0]  bar_idx;
    logic [5:0]  bar_val;
    logic        busy;
    logic        frame_skipped;

    always #20 clk = ~clk;

    bar_update_scheduler dut (
        .clk_25MHz     (clk),
        .rst           (rst),
        .fft_done      (fft_done),
        .vsync         (vsync),
        .bin_rd        (bin_rd),
        .bin_addr      (bin_addr),
        .bin_data      (bin_data),
        .bar_we        (bar_we),
        .bar_idx       (bar_idx),
        .bar_val       (bar_val),
        .busy          (busy),
        .frame_skipped (frame_skipped)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Spectrum memory: one-cycle read latency, junk when not read
    // ------------------------------------------------------------------
    logic [12:0] mem [256];

    initial begin : mem_port
        logic       r;
        logic [7:0] a;
        bin_data = '0;
        forever begin
            @(negedge clk);
            r = bin_rd;
            a = bin_addr;
            @(posedge clk);
            #1;
            bin_data = r ? mem[a] : 13'($urandom);
        end
    end

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    typedef struct packed {
        logic       rd;
        logic [7:0] addr;
        logic       we;
        logic [3:0] idx;
        logic [5:0] val;
    } exp_t;

    localparam int CNT [16] = '{1, 1, 1, 1, 1, 1, 1, 2, 2, 4, 4, 8, 8, 16, 16, 32};

    exp_t       sched [$];
    int         held_m [16];
    logic [7:0] last_addr;
    logic [3:0] last_idx;
    logic [5:0] last_val;
    bit         pend_m;
    bit         h0, h1;

    // Observations for directed scenarios
    logic [9:0] wq [$];   // {bar_idx, bar_val} per write
    logic [7:0] aq [$];   // bin_addr per read
    int         busy_cnt;
    int         skip_cnt;

    function automatic void model_clear();
        sched.delete();
        for (int i = 0; i < 16; i++) held_m[i] = 0;
        last_addr = '0;
        last_idx  = '0;
        last_val  = '0;
        pend_m    = 1'b0;
        h0        = 1'b0;
        h1        = 1'b0;
    endfunction

    // Expected outputs for every cycle of one sequence, starting the cycle
    // after the start detection. Bars cover consecutive bins from bin 2.
    function automatic void build_schedule();
        int         first = 2;
        logic [7:0] a  = last_addr;
        logic [3:0] ix = last_idx;
        logic [5:0] v  = last_val;
        for (int b = 0; b < 16; b++) begin
            int sum = 0;
            int nv;
            for (int k = 0; k < CNT[b]; k++) begin
                a = 8'(first + k);
                sum += int'(mem[a]) / 256;
                sched.push_back('{rd: 1'b1, addr: a, we: 1'b0, idx: ix, val: v});
            end
            sched.push_back('{rd: 1'b0, addr: a, we: 1'b0, idx: ix, val: v});
            nv = (sum / CNT[b]) / 8 + (held_m[b] * 7) / 8;
            if (nv > 63) nv = 63;
            held_m[b] = nv;
            ix = 4'(b);
            v  = 6'(nv);
            sched.push_back('{rd: 1'b0, addr: a, we: 1'b1, idx: ix, val: v});
            first += CNT[b];
        end
    endfunction

    initial begin : compare
        model_clear();
        busy_cnt = 0;
        skip_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("rst_bin_rd", 32'(bin_rd), 0);
                check("rst_bin_addr", 32'(bin_addr), 0);
                check("rst_bar_we", 32'(bar_we), 0);
                check("rst_bar_idx", 32'(bar_idx), 0);
                check("rst_bar_val", 32'(bar_val), 0);
                check("rst_busy", 32'(busy), 0);
                check("rst_frame_skipped", 32'(frame_skipped), 0);
                model_clear();
            end else begin
                exp_t e;
                bit   fs;
                bit   busy_m;
                bit   start;
                fs     = !h1 && h0;
                busy_m = (sched.size() != 0);
                if (busy_m) e = sched[0];
                else        e = '{rd: 1'b0, addr: last_addr, we: 1'b0, idx: last_idx, val: last_val};

                check("bin_rd", 32'(bin_rd), 32'(e.rd));
                check("bin_addr", 32'(bin_addr), 32'(e.addr));
                check("bar_we", 32'(bar_we), 32'(e.we));
                check("bar_idx", 32'(bar_idx), 32'(e.idx));
                check("bar_val", 32'(bar_val), 32'(e.val));
                check("busy", 32'(busy), 32'(busy_m));
                check("frame_skipped", 32'(frame_skipped), 32'(fs && busy_m));

                if (bar_we) wq.push_back({bar_idx, bar_val});
                if (bin_rd) aq.push_back(bin_addr);
                if (busy) busy_cnt++;
                if (frame_skipped) skip_cnt++;

                start = fs && pend_m && !busy_m;
                if (busy_m) begin
                    e = sched.pop_front();
                    last_addr = e.addr;
                    last_idx  = e.idx;
                    last_val  = e.val;
                end
                if (fft_done)   pend_m = 1'b1;
                else if (start) pend_m = 1'b0;
                if (start) build_schedule();
                h1 = h0;
                h0 = vsync;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wq.delete();
        aq.delete();
        busy_cnt = 0;
        skip_cnt = 0;
    endtask

    task automatic fill(input logic [12:0] v);
        for (int i = 0; i < 256; i++) mem[i] = v;
    endtask

    task automatic pulse_fft();
        fft_done = 1'b1;
        tick();
        fft_done = 1'b0;
    endtask

    task automatic vsync_rise();
        vsync = 1'b0;
        tick();
        vsync = 1'b1;
        tick();
    endtask

    task automatic wait_busy(input string name);
        int n = 0;
        while (!busy && n < 8) begin
            tick();
            n++;
        end
        check({name, "_started"}, 32'(busy), 1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        check({name, "_ended"}, 32'(busy), 0);
    endtask

    task automatic check_writes(input string name, input int v);
        check({name, "_nwrites"}, 32'(wq.size()), 16);
        for (int i = 0; i < wq.size() && i < 16; i++) begin
            check({name, "_idx"}, 32'(wq[i][9:6]), i);
            check({name, "_val"}, 32'(wq[i][5:0]), v);
        end
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    initial begin : stimulus
        int vals [3] = '{3, 5, 7};

        rst      = 1'b0;
        fft_done = 1'b0;
        vsync    = 1'b0;
        fill('0);
        repeat (3) tick();
        check("reset_busy", 32'(busy), 0);
        check("reset_bar_we", 32'(bar_we), 0);

        // Frame start without a pending spectrum does nothing.
        rst = 1'b1;
        tick();
        clear_mon();
        vsync_rise();
        repeat (10) tick();
        check("idle_reads", 32'(aq.size()), 0);
        check("idle_writes", 32'(wq.size()), 0);
        check("idle_busy_cycles", 32'(busy_cnt), 0);

        // Full-scale bins, three updates: 3, then 5, then 7.
        fill(13'h1FFF);
        for (int r = 0; r < 3; r++) begin
            clear_mon();
            pulse_fft();
            vsync_rise();
            wait_busy("allmax");
            wait_idle("allmax");
            check_writes("allmax", vals[r]);
            if (r == 0) begin
                check("busy_cycles", 32'(busy_cnt), 131);
                check("nreads", 32'(aq.size()), 99);
                for (int i = 0; i < aq.size(); i++) check("addr_seq", 32'(aq[i]), i + 2);
            end
        end

        // Only bar 15's bins carry energy: bar 15 gets 2, others 0.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        fill('0);
        for (int b = 69; b <= 100; b++) mem[b] = 13'(16 << 8);
        clear_mon();
        pulse_fft();
        vsync_rise();
        wait_busy("bar15");
        wait_idle("bar15");
        check("bar15_nwrites", 32'(wq.size()), 16);
        for (int i = 0; i < wq.size() && i < 16; i++) begin
            check("bar15_idx", 32'(wq[i][9:6]), i);
            check("bar15_val", 32'(wq[i][5:0]), (i == 15) ? 2 : 0);
        end

        // Second frame start around busy cycle 50 is skipped, not restarted.
        fill(13'h1FFF);
        clear_mon();
        pulse_fft();
        vsync_rise();
        wait_busy("skip");
        vsync = 1'b0;
        repeat (48) tick();
        vsync = 1'b1;
        wait_idle("skip");
        check("skip_pulses", 32'(skip_cnt), 1);
        check("skip_nwrites", 32'(wq.size()), 16);
        for (int i = 0; i < wq.size() && i < 16; i++) check("skip_idx", 32'(wq[i][9:6]), i);
        repeat (20) tick();
        check("skip_no_restart", 32'(wq.size()), 16);

        // Reset during bar 9 aborts; afterwards a fresh spectrum gives 3s.
        clear_mon();
        pulse_fft();
        vsync_rise();
        begin
            int n = 0;
            while (wq.size() < 9 && n < 200) begin
                tick();
                n++;
            end
        end
        check("reached_bar9", 32'(wq.size()), 9);
        repeat (3) tick();
        rst = 1'b0;
        #1;
        check("abort_bin_rd", 32'(bin_rd), 0);
        check("abort_busy", 32'(busy), 0);
        tick();
        rst = 1'b1;
        tick();
        clear_mon();
        vsync_rise();
        repeat (20) tick();
        check("abort_no_resume", 32'(wq.size()), 0);
        clear_mon();
        pulse_fft();
        vsync_rise();
        wait_busy("after_reset");
        wait_idle("after_reset");
        check_writes("after_reset", 3);

        // Randomized traffic against the model.
        for (int round = 0; round < 6; round++) begin
            fft_done = 1'b0;
            rst      = 1'b1;
            wait_idle("rand_quiet");
            for (int i = 0; i < 256; i++) begin
                mem[i] = (round == 2) ? 13'h1FFF : 13'($urandom);
            end
            for (int c = 0; c < 400; c++) begin
                fft_done = ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 39) == 0) vsync = ~vsync;
                rst = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
                tick();
            end
        end

        fft_done = 1'b0;
        rst      = 1'b1;
        wait_idle("final");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bar_update_scheduler.md
BAR_UPDATE_SCHEDULER -- requirements
Module: bar_update_scheduler

Interface
REQ-001 Parameters: WIDTH=12, sample magnitude is WIDTH+1 bits; N=256, spectrum bins; BARS=16, display bars; BAR_W=6, bar value width.
REQ-002 clk_25MHz  in  1  single clock; all logic is clocked on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 fft_done  in  1  one-cycle pulse indicating that a new spectrum is ready in bin memory.
REQ-005 vsync  in  1  VGA vertical sync, synchronous to clk_25MHz.
REQ-006 bin_rd  out  1  read strobe to the spectrum memory.
REQ-007 bin_addr  out  8  bin index; valid when bin_rd=1.
REQ-008 bin_data  in  WIDTH+1  read data; valid exactly 1 cycle after bin_rd.
REQ-009 bar_we  out  1  one-cycle write strobe to the bar register file.
REQ-010 bar_idx  out  4  bar being written; valid when bar_we=1.
REQ-011 bar_val  out  BAR_W  smoothed bar height; valid when bar_we=1.
REQ-012 busy  out  1  high while an update sequence is running.
REQ-013 frame_skipped  out  1  one-cycle pulse when a trigger arrives while busy.

Function
REQ-014 Frame start is a vsync rising edge, detected with a 2-bit shift register; detection fires when the sampled history equals 01.
REQ-015 A pending flag is set by fft_done and cleared on the cycle a sequence starts; fft_done in the start cycle leaves pending set.
REQ-016 Start conditions: a frame start with pending=1 and state IDLE starts a sequence; a frame start with pending=0 does nothing.
REQ-017 Frame start while busy: pulse frame_skipped; the running sequence is unaffected; pending is unaffected.
REQ-018 Bin map (bar: first bin, count):
- bars 0-6: bins 2-8, count 1;
- bar 7: 9, 2; bar 8: 11, 2;
- bar 9: 13, 4; bar 10: 17, 4;
- bar 11: 21, 8; bar 12: 29, 8;
- bar 13: 37, 16; bar 14: 53, 16;
- bar 15: 69, 32.
- Map is held in a constant table indexed by bar.
REQ-019 FSM states: IDLE, ISSUE, LAST, COMMIT.
- IDLE -> ISSUE on start.
- ISSUE asserts bin_rd for count consecutive cycles with ascending bin_addr, then goes to LAST.
- LAST accumulates the final datum, then goes to COMMIT.
- COMMIT asserts bar_we, then goes to ISSUE for bar+1, or to IDLE after bar 15.
REQ-020 Accumulation per bin: bin_data>>8 (5 bits) is added to a 10-bit accumulator, which is cleared at the first ISSUE cycle of each bar.
REQ-021 Average: avg = acc >> log2(count).
REQ-022 Smoothing: new = (avg>>3) + ((old*7)>>3).
- old is the internally held BAR_W-bit value for that bar.
- Intermediate products are at least 9 bits wide.
- The result saturates at 63.
- The result is stored back as old and driven on bar_val.
REQ-023 Timing:
- First bin_rd is in the cycle after start detection.
- Each bar takes count+2 cycles.
- A full sequence takes 131 cycles; busy is high for exactly those cycles.
- bar_we for bar 15 is in the 131st cycle.
REQ-024 Outside the ISSUE state, bin_rd=0. Outside COMMIT, bar_we=0. bin_addr, bar_idx and bar_val hold their last values when not strobed.
REQ-025 Bars are written strictly in order 0..15, each exactly once per sequence.

Reset
REQ-026 While rst=0, the following are 0: state (IDLE), pending, vsync history, accumulator, all 16 held bar values, and all outputs.
REQ-027 Reset asserted mid-sequence aborts the sequence immediately; no further bar_we occurs; after release, a new fft_done and frame start are required before the next sequence.

Verification
REQ-028 Reset: rst=0 then released -> all outputs 0; a vsync rise without fft_done gives no bin_rd and no bar_we.
REQ-029 All bins=0x1FFF, fft_done, vsync rise -> 16 writes of bar_val=3. Repeat -> 16 writes of 5. Repeat -> 16 writes of 7.
REQ-030 Address check -> bin_addr sequence is 2..8, 9,10, 11,12, 13..16, 17..20, 21..28, 29..36, 37..52, 53..68, 69..100; busy=1 for exactly 131 cycles.
REQ-031 Bins 69..100 = 16<<8, others 0, one update -> bar 15 bar_val=2; all other bars 0.
REQ-032 Second vsync rise at cycle 50 of busy -> frame_skipped pulses once; the sequence completes normally with 16 writes.
REQ-033 rst=0 during bar 9 -> outputs 0 within the reset assertion; held bars cleared; the next sequence from all-0x1FFF bins yields 3 for every bar.
